// File: rtl/poly_nco.sv
// Time-multiplexed polyphonic oscillator bank: one shared phase/wave/multiply/accumulate
// pipeline visits every voice once per sample tick and emits a saturated mixed sample.
module poly_nco #(
    parameter int VOICES  = 8,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 16,
    parameter int AMP_W   = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       tick,
    input  logic                       wr_en,
    input  logic [$clog2(VOICES)-1:0]  wr_voice,
    input  logic [1:0]                 wr_field,
    input  logic [PHASE_W-1:0]         wr_data,
    output logic [OUT_W-1:0]           out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int VW = $clog2(VOICES);
    localparam int AW = OUT_W + VW;
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    // sweep control
    logic                busy_q, busy_d;
    logic                issuing_q, issuing_d;
    logic [VW-1:0]       issue_cnt_q, issue_cnt_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic                accept;

    // pipeline registers
    logic                s0_vld_q, s0_vld_d, s0_last_q, s0_last_d, s0_act_q, s0_act_d;
    logic [OUT_W-1:0]    s0_p_q, s0_p_d;
    logic [1:0]          s0_shape_q, s0_shape_d;
    logic [AMP_W-1:0]    s0_amp_q, s0_amp_d;
    logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [OUT_W-1:0]    wave_q, wave_d;
    logic [AMP_W-1:0]    s1_amp_q, s1_amp_d;
    logic                s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [OUT_W-1:0]    prod_q, prod_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                fin_q, fin_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                ovr_pend_q, ovr_pend_d;
    logic                overrun_q, overrun_d;

    // per-voice register read-out for the S0 mux
    logic [OUT_W-1:0]    phase_top_all [VOICES];
    logic [AMP_W-1:0]    amp_all       [VOICES];
    logic [1:0]          shape_all     [VOICES];
    logic                gate_all      [VOICES];
    logic                gprev_all     [VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic [PHASE_W-1:0] freq_q, freq_d, phase_q, phase_d;
            logic [AMP_W-1:0]   amp_q, amp_d;
            logic [1:0]         shape_q, shape_d;
            logic               gate_q, gate_d, gprev_q, gprev_d;
            logic               wr_hit, s0_hit;

            assign wr_hit = wr_en && (wr_voice == VW'(gi));
            assign s0_hit = issuing_q && (issue_cnt_q == VW'(gi));

            always_comb begin
                freq_d  = freq_q;
                amp_d   = amp_q;
                shape_d = shape_q;
                gate_d  = gate_q;
                phase_d = phase_q;
                gprev_d = gprev_q;
                if (wr_hit) begin
                    case (wr_field)
                        2'd0:    freq_d  = wr_data;
                        2'd1:    amp_d   = wr_data[AMP_W-1:0];
                        2'd2:    shape_d = wr_data[1:0];
                        default: gate_d  = wr_data[0];
                    endcase
                end
                // S0 reads the pre-edge register values, so a colliding write lands next sweep
                if (s0_hit) begin
                    gprev_d = gate_q;
                    if (!gate_q)
                        phase_d = '0;
                    else if (!gprev_q)
                        phase_d = freq_q;
                    else
                        phase_d = phase_q + freq_q;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    freq_q  <= '0;
                    amp_q   <= '0;
                    shape_q <= '0;
                    gate_q  <= 1'b0;
                    phase_q <= '0;
                    gprev_q <= 1'b0;
                end else begin
                    freq_q  <= freq_d;
                    amp_q   <= amp_d;
                    shape_q <= shape_d;
                    gate_q  <= gate_d;
                    phase_q <= phase_d;
                    gprev_q <= gprev_d;
                end
            end

            assign phase_top_all[gi] = phase_q[PHASE_W-1 -: OUT_W];
            assign amp_all[gi]       = amp_q;
            assign shape_all[gi]     = shape_q;
            assign gate_all[gi]      = gate_q;
            assign gprev_all[gi]     = gprev_q;
        end
    endgenerate

    // S1 waveform shaping
    logic [OUT_W-1:0] tri_u;
    always_comb begin
        tri_u = {s0_p_q[OUT_W-1] ? ~s0_p_q[OUT_W-2:0] : s0_p_q[OUT_W-2:0], 1'b0};
        case (s0_shape_q)
            2'd0:    wave_d = {~s0_p_q[OUT_W-1], s0_p_q[OUT_W-2:0]};
            2'd1:    wave_d = s0_p_q[OUT_W-1] ? NEG_MAX : POS_MAX;
            2'd2:    wave_d = {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
            default: wave_d = lfsr_q[31 -: OUT_W];
        endcase
        if (!s0_act_q)
            wave_d = '0;
    end

    // S2 full-precision signed x unsigned product, floor-shifted by AMP_W
    logic signed [OUT_W+AMP_W:0] mult_full;
    logic                        unused_mult;
    assign mult_full   = $signed(wave_q) * $signed({1'b0, s1_amp_q});
    assign unused_mult = ^{mult_full[AMP_W-1:0], mult_full[OUT_W+AMP_W]};

    logic [VW:0]      acc_top;
    logic [OUT_W-1:0] acc_sat;
    assign acc_top = acc_q[AW-1:OUT_W-1];
    assign acc_sat = ((acc_top == '0) || (acc_top == '1)) ? acc_q[OUT_W-1:0]
                   : (acc_q[AW-1] ? MIN_VAL : POS_MAX);

    always_comb begin
        busy_d      = busy_q;
        issuing_d   = issuing_q;
        issue_cnt_d = issue_cnt_q;
        lfsr_d      = lfsr_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovr_pend_d  = 1'b0;
        overrun_d   = ovr_pend_q;
        // the completing edge also frees the datapath for a back-to-back tick
        accept      = tick && (!busy_q || fin_q);

        if (fin_q) begin
            out_d       = acc_sat;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
        end
        if (s2_vld_q)
            acc_d = acc_q + {{VW{prod_q[OUT_W-1]}}, prod_q};
        if (issuing_q) begin
            issue_cnt_d = issue_cnt_q + VW'(1);
            if (issue_cnt_q == VW'(VOICES-1))
                issuing_d = 1'b0;
        end
        if (accept) begin
            busy_d      = 1'b1;
            issuing_d   = 1'b1;
            issue_cnt_d = '0;
            acc_d       = '0;
            lfsr_d      = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end else if (tick) begin
            ovr_pend_d  = 1'b1;
        end

        s0_vld_d   = issuing_q;
        s0_last_d  = issuing_q && (issue_cnt_q == VW'(VOICES-1));
        s0_act_d   = gate_all[issue_cnt_q];
        s0_p_d     = (gate_all[issue_cnt_q] && gprev_all[issue_cnt_q]) ? phase_top_all[issue_cnt_q] : '0;
        s0_shape_d = shape_all[issue_cnt_q];
        s0_amp_d   = amp_all[issue_cnt_q];

        s1_vld_d   = s0_vld_q;
        s1_last_d  = s0_last_q;
        s1_amp_d   = s0_amp_q;
        s2_vld_d   = s1_vld_q;
        s2_last_d  = s1_last_q;
        prod_d     = mult_full[AMP_W +: OUT_W];
        fin_d      = s2_vld_q && s2_last_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q      <= 1'b0;
            issuing_q   <= 1'b0;
            issue_cnt_q <= '0;
            lfsr_q      <= 32'd1;
            s0_vld_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_act_q    <= 1'b0;
            s0_p_q      <= '0;
            s0_shape_q  <= '0;
            s0_amp_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            wave_q      <= '0;
            s1_amp_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            fin_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovr_pend_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            issuing_q   <= issuing_d;
            issue_cnt_q <= issue_cnt_d;
            lfsr_q      <= lfsr_d;
            s0_vld_q    <= s0_vld_d;
            s0_last_q   <= s0_last_d;
            s0_act_q    <= s0_act_d;
            s0_p_q      <= s0_p_d;
            s0_shape_q  <= s0_shape_d;
            s0_amp_q    <= s0_amp_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            wave_q      <= wave_d;
            s1_amp_q    <= s1_amp_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            fin_q       <= fin_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovr_pend_q  <= ovr_pend_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
